// File: rtl/bin2bcd_pkg.sv
// bin2bcd_pkg: shared state encoding, nibble width and decimal range helpers
package bin2bcd_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    localparam int NIBBLE_W = 4;
    function automatic int pow10(input int n);
        int r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction
    function automatic int max_bcd(input int digits);
        return pow10(digits) - 1;
    endfunction
endpackage

// File: rtl/bin2bcd_seq_if.sv
// bin2bcd_seq_if: start/busy/done request and packed BCD result bundle
interface bin2bcd_seq_if
    import bin2bcd_pkg::*;
#(
    parameter int IN_W = 8,
    parameter int DIGITS = 2
);
    logic start;
    logic [IN_W-1:0] bin_in;
    logic busy;
    logic done;
    logic [NIBBLE_W*DIGITS-1:0] bcd_out;
    logic overflow;
    logic [DIGITS-1:0] blank;
    modport master (output start, bin_in, input busy, done, bcd_out, overflow, blank);
    modport slave (input start, bin_in, output busy, done, bcd_out, overflow, blank);
endinterface

// File: rtl/bcd_add3.sv
// bcd_add3: double-dabble nibble correction, adds 3 when the nibble is 5 or more
module bcd_add3 (
    input  logic [3:0] in,
    output logic [3:0] out
);
    assign out = (in >= 4'd5) ? in + 4'd3 : in;
endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble binary-to-BCD converter, start/busy/done handshake
// Define BCD_BLANK_EN to drive a leading-zero blank mask; otherwise blank is tied to 0.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int IN_W = 8,
    parameter int DIGITS = 2
) (
    input logic clk,
    input logic rst,
    bin2bcd_seq_if.slave bus
);
    localparam int SW = NIBBLE_W * (DIGITS + 1);
    localparam int OW = NIBBLE_W * DIGITS;
    localparam int CW = $clog2(IN_W + 1);
    localparam int MAXV = max_bcd(DIGITS);
    state_t state;
    logic [IN_W-1:0] shreg;
    logic [SW-1:0] scratch, fixed, scratch_d;
    logic [CW-1:0] count;
    logic ovf_q, busy_q, done_q, overflow_q, last, accept;
    logic [OW-1:0] bcd_q, bcd_d;

    for (genvar i = 0; i <= DIGITS; i++) begin : g_add3
        bcd_add3 u_add3 (
            .in (scratch[NIBBLE_W*i +: NIBBLE_W]),
            .out(fixed[NIBBLE_W*i +: NIBBLE_W])
        );
    end

    assign scratch_d = SW'({fixed, shreg[IN_W-1]});
    assign bcd_d = ovf_q ? {DIGITS{4'h9}} : scratch_d[OW-1:0];
    assign last = (state == SHIFT) && (count == CW'(IN_W - 1));
    assign accept = bus.start && (state != SHIFT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            shreg      <= '0;
            scratch    <= '0;
            count      <= '0;
            ovf_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            bcd_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state == SHIFT) begin
                scratch <= scratch_d;
                shreg   <= shreg << 1;
                count   <= count + 1'b1;
                if (last) begin
                    state      <= DONE;
                    busy_q     <= 1'b0;
                    done_q     <= 1'b1;
                    bcd_q      <= bcd_d;
                    overflow_q <= ovf_q;
                end
            end else if (accept) begin
                state   <= SHIFT;
                busy_q  <= 1'b1;
                shreg   <= bus.bin_in;
                scratch <= '0;
                count   <= '0;
                ovf_q   <= 32'(bus.bin_in) > MAXV;
            end else begin
                state <= IDLE;
            end
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.bcd_out  = bcd_q;
    assign bus.overflow = overflow_q;

`ifdef BCD_BLANK_EN
    logic [DIGITS-1:0] blank_q, blank_d;
    logic blank_run;
    // A digit blanks only while every digit above it is also zero; digit 0 always shows.
    always_comb begin
        blank_d = '0;
        blank_run = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            blank_run = blank_run && (bcd_d[NIBBLE_W*i +: NIBBLE_W] == 4'd0);
            blank_d[i] = blank_run;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) blank_q <= '0;
        else if (last) blank_q <= blank_d;
    end
    assign bus.blank = blank_q;
`else
    assign bus.blank = '0;
`endif
endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
Sequential double-dabble binary-to-BCD converter. Sits between the FSM (8-bit `num` producer) and the seven-segment scanning display, which needs packed BCD digits. It converts one value per start request and uses a start/busy/done handshake. It holds the last result stable for the display between conversions.

Parameters:
IN_W, 8, width of the binary input.
DIGITS, 2, number of BCD output digits (4 bits each); matches the two-digit display.

Ports:
clk  input  1  system clock; all logic rising-edge.
rst  input  1  synchronous reset, active-high.
start  input  1  conversion request; sampled only when busy=0.
bin_in  input  IN_W  binary value; latched on the accepted start cycle.
busy  output  1  high while a conversion is in progress.
done  output  1  single-cycle pulse when bcd_out/overflow update.
bcd_out  output  4*DIGITS  packed BCD; digit 0 in bits [3:0].
overflow  output  1  last converted value exceeded 10^DIGITS-1.
blank  output  DIGITS  leading-zero blank mask (see Optional Feature).

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: state=IDLE; busy=0, done=0, bcd_out=0, overflow=0, blank=0. All internal shift/count registers are cleared.
- Reset mid-conversion: the conversion is aborted on the next edge. No done pulse is issued. Outputs go to their reset values.
- States:
  - IDLE: busy=0. If start=1, latch bin_in into the shift register, clear the BCD scratch, set count=0, and go to SHIFT.
  - SHIFT: busy=1. Each cycle, every scratch nibble that is >=5 gets +3 (all nibbles in parallel). Then {scratch, shift} shifts left by 1 and count increments. After exactly IN_W shift cycles, go to DONE.
  - DONE: busy=0, done=1 for this cycle only. bcd_out, overflow and blank are registered on the DONE entry edge, so they are valid while done=1. Next state is IDLE. If start=1 in this cycle, the request is accepted and the block goes to SHIFT, giving back-to-back conversions.
- Latency: start accepted at edge N means busy=1 from N+1 to N+IN_W, and done=1 during cycle N+IN_W+1.
- start while busy=1 is ignored; it is neither queued nor allowed to corrupt the conversion in progress.
- Scratch width is 4*(DIGITS+1), so the internal conversion never truncates.
- Overflow: computed from the latched value at start against MAXV = 10^DIGITS - 1 (a package function).
  - If value > MAXV: overflow=1 and bcd_out saturates to all nines.
  - Otherwise overflow=0 and bcd_out equals the low DIGITS nibbles of the scratch.
- bcd_out and overflow hold their values between done pulses; they change only on a DONE entry edge or on reset.
- bin_in changing during SHIFT has no effect.

Optional Feature:
BCD_BLANK_EN
- Defined: blank[i]=1 when digit i and every digit above it are zero, for i>=1. blank[0] is always 0. The mask is registered together with bcd_out. On overflow, blank=0.
- Undefined: the blank port still exists, tied to 0; no extra logic is generated.

Decomposition:
- Package bin2bcd_pkg:
  - state encoding (IDLE/SHIFT/DONE)
  - NIBBLE_W=4
  - function pow10(n)
  - function max_bcd(digits) returning 10^digits-1
- One sub-module: bcd_add3, a combinational 4-bit nibble corrector (out = in>=5 ? in+3 : in). It is instantiated DIGITS+1 times via generate.
- The FSM, counter and output registers stay in bin2bcd_seq.

Test Plan:
- Reset, then start with bin_in=0 → done at cycle 9 after accept; bcd_out=0x00, overflow=0; with BCD_BLANK_EN, blank=2'b10.
- bin_in=99 → busy high for 8 cycles, then done; bcd_out=0x99, overflow=0, blank=0.
- bin_in=100, then bin_in=255 → both give bcd_out=0x99, overflow=1, blank=0.
- bin_in=7, then start pulsed and bin_in changed to 42 mid-SHIFT → bcd_out=0x07; the mid-SHIFT start produces no second done.
- start held high continuously with bin_in=37 then 58 → each done is followed by an immediate accept; bcd_out sequence 0x37, 0x58; done period is 9 cycles.
- rst asserted at cycle 4 of the SHIFT for bin_in=45 → busy=0, bcd_out=0, no done; a fresh start with bin_in=45 gives 0x45.
